// File: rtl/m92_sound_latch.sv
// Main-CPU <-> sound-CPU command/reply channel: a small show-ahead FIFO carries
// commands to the sound CPU, and a single reply latch carries answers back.
module m92_sound_latch #(
  parameter int          DEPTH     = 4,
  parameter logic [7:0]  EMPTY_VAL = 8'hff
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  input  logic                       main_wr,
  input  logic [7:0]                 main_din,
  input  logic                       main_rd,
  output logic [7:0]                 main_dout,
  output logic                       main_irq,
  output logic [1:0]                 main_status,
  input  logic                       snd_rd,
  output logic [7:0]                 snd_dout,
  output logic                       snd_irq,
  input  logic                       snd_wr,
  input  logic [7:0]                 snd_din,
  output logic [$clog2(DEPTH):0]     snd_level,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       reply_q, reply_d;
  logic             reply_valid_q, reply_valid_d;
  logic             main_irq_q, main_irq_d;

  logic fifo_empty;
  logic fifo_full;
  logic do_pop;
  logic do_push;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);

  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign do_pop  = snd_rd && !fifo_empty;
  assign do_push = main_wr && (!fifo_full || do_pop);

  always_comb begin
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = main_din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else if (main_wr) begin
      overflow_d = 1'b1;
    end

    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // A reply write outranks a simultaneous main-side read.
  always_comb begin
    reply_d       = reply_q;
    reply_valid_d = reply_valid_q;
    main_irq_d    = snd_wr;

    if (snd_wr) begin
      reply_d       = snd_din;
      reply_valid_d = 1'b1;
    end else if (main_rd) begin
      reply_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mem_q         <= '{default: '0};
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      reply_q       <= EMPTY_VAL;
      reply_valid_q <= 1'b0;
      main_irq_q    <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      reply_q       <= reply_d;
      reply_valid_q <= reply_valid_d;
      main_irq_q    <= main_irq_d;
    end
  end

  assign snd_dout    = fifo_empty ? EMPTY_VAL : mem_q[rd_ptr_q];
  assign snd_irq     = !fifo_empty;
  assign snd_level   = count_q;
  assign overflow    = overflow_q;
  assign main_dout   = reply_q;
  assign main_irq    = main_irq_q;
  assign main_status = {reply_valid_q, fifo_full};

endmodule
